coax_rx_buffer: RTL

Downstream stage of coax_rx. Captures each received 10-bit word and each receiver error into a synchronous FIFO, tagged with frame-start and error flags. Delimits frames using the receiver's active indication. Presents a pull-style read port to the host/SPI register interface, with occupancy and sticky overflow status.

---
 rtl/coax_rx_buffer_pkg.sv | 32 +++
 rtl/coax_rx_buffer_fifo_sync.sv | 76 +++++++
 rtl/coax_rx_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/coax_rx_buffer_pkg.sv
// coax_rx_buffer shared definitions: entry layout, FSM encodings,
// and the entry packing helper.
package coax_rx_buffer_pkg;

   localparam int ENTRY_W   = 16;
   localparam int ERR_BIT   = 15;
   localparam int START_BIT = 14;
   localparam int CODE_MSB  = 13;
   localparam int CODE_LSB  = 10;
   localparam int DATA_MSB  = 9;
   localparam int DATA_LSB  = 0;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RECEIVE = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   function automatic logic [ENTRY_W-1:0] mk_entry(
      input logic       err,
      input logic       start,
      input logic [3:0] code,
      input logic [9:0] data
   );
      logic [ENTRY_W-1:0] e;
      e = '0;
      e[ERR_BIT]             = err;
      e[START_BIT]           = start;
      e[CODE_MSB:CODE_LSB]   = code;
      e[DATA_MSB:DATA_LSB]   = data;
      return e;
   endfunction

endpackage

// File: rtl/coax_rx_buffer_fifo_sync.sv
// Synchronous FIFO with registered read data, occupancy counter
// and registered empty/full flags.
module coax_rx_buffer_fifo_sync #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 16,
   parameter int DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_BITS:0]   count
);

   localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  rd_ok;
   logic                  wr_ok;
   logic [DEPTH_BITS:0]   count_d;

   // A full FIFO still accepts a write when the same edge pops an entry
   assign rd_ok = rd_en && !empty && !clear;
   assign wr_ok = wr_en && (!full || rd_ok) && !clear;

   always_comb begin
      count_d = count;
      if (wr_ok && !rd_ok) begin
         count_d = count + 1'b1;
      end else if (!wr_ok && rd_ok) begin
         count_d = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
         count   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         count <= count_d;
         empty <= (count_d == '0);
         full  <= (count_d == FULL_CNT);
      end
   end

endmodule

// File: rtl/coax_rx_buffer.sv
// Frame tagger and error capture in front of the receive FIFO,
// with sticky overflow status for the host read port.
module coax_rx_buffer
   import coax_rx_buffer_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DEPTH_BITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rx_active,
   input  logic [9:0]          rx_data,
   input  logic                rx_data_valid,
   input  logic [3:0]          rx_error,
   input  logic                rx_error_valid,
   input  logic                rd_en,
   output logic [15:0]         rd_data,
   output logic                empty,
   output logic                full,
   output logic [DEPTH_BITS:0] count,
   output logic                overflow,
   input  logic                clear
);

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   logic               start_q;
   logic               start_d;
   logic               act_q;
   logic               rise;
   logic               wr_req;
   logic [ENTRY_W-1:0] entry;
   logic               drop;

   assign rise = rx_active && !act_q;
   assign drop = wr_req && full && !rd_en && !clear;

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      wr_req  = 1'b0;
      entry   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_error_valid) begin
               wr_req = 1'b1;
               entry  = mk_entry(1'b1, 1'b0, rx_error, 10'd0);
            end else if (rx_data_valid) begin
               wr_req = 1'b1;
               entry  = mk_entry(1'b0, 1'b0, 4'd0, rx_data);
            end
            if (rise) begin
               state_d = ST_RECEIVE;
               start_d = 1'b1;
            end
         end
         ST_RECEIVE: begin
            if (rx_error_valid) begin
               wr_req  = 1'b1;
               entry   = mk_entry(1'b1, start_q, rx_error, 10'd0);
               state_d = ST_DISCARD;
            end else if (rx_data_valid) begin
               wr_req  = 1'b1;
               entry   = mk_entry(1'b0, start_q, 4'd0, rx_data);
               start_d = 1'b0;
            end
            if (drop) begin
               state_d = ST_DISCARD;
            end
            if (!rx_active) begin
               state_d = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (!rx_active) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // act_q resets high so a frame still running at reset release
   // is not mistaken for a new frame start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         act_q    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         act_q <= rx_active;
         if (clear) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            overflow <= 1'b0;
         end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            overflow <= overflow | drop;
         end
      end
   end

   coax_rx_buffer_fifo_sync #(
      .WIDTH      (ENTRY_W),
      .DEPTH      (DEPTH),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .wr_en   (wr_req),
      .wr_data (entry),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

endmodule
